// File: rtl/gate_bist_pkg.sv
// Shared constants and state encoding for the gate-library BIST controller.
package gate_bist_pkg;

    localparam int N_IN_DEF  = 24;
    localparam int N_OUT_DEF = 10;

    // x^24+x^23+x^22+x^17+1 taps on bits 23,22,21,16; x^10+x^3+1 feedback into bits 0 and 3.
    localparam logic [23:0] LFSR_TAPS = 24'hE10000;
    localparam logic [9:0]  MISR_MASK = 10'h009;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/gate_bist_misr.sv
// Multiple-input signature register: shift left, fold the MSB back through MASK, xor in data.
module gate_bist_misr
    import gate_bist_pkg::*;
#(
    parameter int               WIDTH = N_OUT_DEF,
    parameter logic [WIDTH-1:0] MASK  = WIDTH'(MISR_MASK)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] sig_next;

    // NOTE: combinational outputs get a value on every path, so no latch is inferred.
    always_comb begin
        sig_next = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? MASK : '0) ^ data;
    end

    // NOTE: registers use <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (load) begin
            sig <= seed;
        end else if (enable) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST wrapper: LFSR pattern source, pattern counter and IDLE/RUN/DONE sequencing around a MISR.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int              N_IN      = N_IN_DEF,
    parameter int              N_OUT     = N_OUT_DEF,
    parameter int              CNT_W     = 16,
    parameter logic [N_IN-1:0]  LFSR_SEED = 24'h000001,
    parameter logic [N_OUT-1:0] MISR_SEED = 10'h000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_patterns,
    input  logic [N_OUT-1:0]  golden,
    output logic [N_IN-1:0]   pat_out,
    input  logic [N_OUT-1:0]  resp_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_OUT-1:0]  signature,
    output logic [CNT_W-1:0]  pat_idx
);

    localparam logic [N_IN-1:0]  TAPS = N_IN'(LFSR_TAPS);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_e            state;
    logic [N_IN-1:0]   lfsr;
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  last_idx;
    logic              accept;

    assign accept = start && (state != S_RUN);

    // The LFSR and counter freeze on the final pattern so DONE still shows it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            lfsr     <= '0;
            idx      <= '0;
            last_idx <= '0;
        end else if (accept) begin
            lfsr     <= LFSR_SEED;
            idx      <= '0;
            last_idx <= num_patterns - ONE;
            state    <= (num_patterns == '0) ? S_DONE : S_RUN;
        end else if (state == S_RUN) begin
            if (idx == last_idx) begin
                state <= S_DONE;
            end else begin
                lfsr <= {lfsr[N_IN-2:0], ^(lfsr & TAPS)};
                idx  <= idx + ONE;
            end
        end
    end

    gate_bist_misr #(
        .WIDTH (N_OUT),
        .MASK  (N_OUT'(MISR_MASK))
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .enable (state == S_RUN),
        .seed   (MISR_SEED),
        .data   (resp_in),
        .sig    (signature)
    );

    assign pat_out = lfsr;
    assign pat_idx = idx;
    assign busy    = (state == S_RUN);
    assign done    = (state == S_DONE);
    assign pass    = done && (signature == golden);

endmodule
